// File: rtl/microm_pkg.sv
// Shared types for the Microm decoder and execute unit: opcodes, instruction lengths and the
// decoded-instruction record passed between them.
package microm_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MOVI = 3'd1,
    OP_MOVF = 3'd2,
    OP_POPI = 3'd3,
    OP_POPF = 3'd4
  } op_e;

  localparam logic [7:0] OPC_MOVI = 8'h01;
  localparam logic [7:0] OPC_MOVF = 8'h02;
  localparam logic [7:0] OPC_POPI = 8'h03;
  localparam logic [7:0] OPC_POPF = 8'h04;

  localparam int INSTR_REG_W = 3;

  typedef struct packed {
    op_e                    op;
    logic [INSTR_REG_W-1:0] reg_idx;
    logic [31:0]            imm;
  } instr_t;

  function automatic logic opcode_legal(input logic [7:0] b);
    return b inside {OPC_MOVI, OPC_MOVF, OPC_POPI, OPC_POPF};
  endfunction

  // Total encoded length in bytes, including opcode and register bytes.
  function automatic int unsigned instr_len(input op_e op);
    unique case (op)
      OP_MOVI, OP_MOVF: return 6;
      OP_POPI, OP_POPF: return 2;
      default:          return 0;
    endcase
  endfunction

endpackage

// File: rtl/microm_imm_asm.sv
// Little-endian immediate assembly register: writes one byte lane per load, clear has priority.
module microm_imm_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [1:0]  sel,
  input  logic [7:0]  byte_in,
  output logic [31:0] imm
);

  logic [31:0] imm_q, imm_d;

  always_comb begin
    // NOTE: defaults first, so every path through this block assigns imm_d and no latch is inferred.
    imm_d = imm_q;
    if (clr) begin
      imm_d = '0;
    end else if (load) begin
      imm_d[8*sel +: 8] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: this register is reset (unlike a data RAM) because the issued immediate must read 0 after reset.
    if (rst) begin
      imm_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      imm_q <= imm_d;
    end
  end

  assign imm = imm_q;

endmodule

// File: rtl/microm_decode.sv
// Byte-stream decoder for Microm bytecode: assembles op/reg/imm, validates them and issues one
// instruction at a time to the execute unit; halts with the faulting opcode offset on illegal input.
module microm_decode
  import microm_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int PC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [2:0]       iss_op,
  output logic [REG_W-1:0] iss_reg,
  output logic [31:0]      iss_imm,
  output logic [PC_W-1:0]  pc,
  output logic             err,
  output logic [PC_W-1:0]  err_pc
);

  typedef enum logic [2:0] {S_OP, S_REG, S_IMM, S_ISSUE, S_ERR} state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [REG_W-1:0] reg_q, reg_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  op_pc_q, op_pc_d;
  logic [PC_W-1:0]  err_pc_q, err_pc_d;
  logic             err_q, err_d;
  logic             imm_clr, imm_load;
  logic             xfer;
  logic [31:0]      imm;
  instr_t           iss_instr;

  // Pure state decode: in_ready never depends combinationally on iss_ready.
  assign in_ready = (state_q == S_OP) || (state_q == S_REG) || (state_q == S_IMM);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    op_pc_d  = op_pc_q;
    err_d    = err_q;
    err_pc_d = err_pc_q;
    imm_clr  = 1'b0;
    imm_load = 1'b0;
    pc_d     = xfer ? pc_q + 1'b1 : pc_q;

    unique case (state_q)
      S_OP: if (xfer) begin
        if (opcode_legal(in_data)) begin
          op_d    = op_e'(in_data[2:0]);
          op_pc_d = pc_q;
          state_d = S_REG;
        end else begin
          err_d    = 1'b1;
          err_pc_d = pc_q;
          state_d  = S_ERR;
        end
      end
      S_REG: if (xfer) begin
        if (int'(in_data) >= NUM_REGS) begin
          err_d    = 1'b1;
          err_pc_d = op_pc_q;
          state_d  = S_ERR;
        end else begin
          reg_d = in_data[REG_W-1:0];
          if (instr_len(op_q) == 6) begin
            cnt_d   = 2'd0;
            state_d = S_IMM;
          end else begin
            imm_clr = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_IMM: if (xfer) begin
        imm_load = 1'b1;
        if (cnt_q == 2'd3) state_d = S_ISSUE;
        else               cnt_d   = cnt_q + 2'd1;
      end
      S_ISSUE: if (iss_ready) state_d = S_OP;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OP;
      op_q     <= OP_NONE;
      reg_q    <= '0;
      cnt_q    <= '0;
      pc_q     <= '0;
      op_pc_q  <= '0;
      err_q    <= 1'b0;
      err_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      op_pc_q  <= op_pc_d;
      err_q    <= err_d;
      err_pc_q <= err_pc_d;
    end
  end

  microm_imm_asm u_imm_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (imm_clr),
    .load    (imm_load),
    .sel     (cnt_q),
    .byte_in (in_data),
    .imm     (imm)
  );

  assign iss_instr = '{op: op_q, reg_idx: INSTR_REG_W'(reg_q), imm: imm};

  assign iss_valid = (state_q == S_ISSUE);
  assign iss_op    = iss_instr.op;
  assign iss_reg   = REG_W'(iss_instr.reg_idx);
  assign iss_imm   = iss_instr.imm;
  assign pc        = pc_q;
  assign err       = err_q;
  assign err_pc    = err_pc_q;

endmodule

// File: tb/tb_microm_decode.sv
// Randomized and directed bench for microm_decode against a byte-stream parsing model.
module tb_microm_decode;

  localparam int NUM_REGS = 8;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rg;
    logic [31:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [2:0]  iss_op;
  logic [2:0]  iss_reg;
  logic [31:0] iss_imm;
  logic [15:0] pc;
  logic        err;
  logic [15:0] err_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] stream[$];
  exp_t       exp_q[$];
  int         exp_consumed;
  logic       exp_err;
  logic [15:0] exp_err_pc;

  microm_decode #(.NUM_REGS(8), .REG_W(3), .PC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_op    (iss_op),
    .iss_reg   (iss_reg),
    .iss_imm   (iss_imm),
    .pc        (pc),
    .err       (err),
    .err_pc    (err_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Walk the byte stream by the encoding rules and list what the decoder should issue.
  function automatic void parse();
    int i = 0;
    exp_t e;
    exp_q.delete();
    exp_err    = 1'b0;
    exp_err_pc = '0;
    while (i < stream.size()) begin
      if (stream[i] < 8'd1 || stream[i] > 8'd4) begin
        exp_err = 1'b1; exp_err_pc = 16'(i); i = i + 1;
        break;
      end
      if (i + 1 >= stream.size()) break;
      if (int'(stream[i+1]) >= NUM_REGS) begin
        exp_err = 1'b1; exp_err_pc = 16'(i); i = i + 2;
        break;
      end
      e.op  = stream[i][2:0];
      e.rg  = stream[i+1][2:0];
      e.imm = 0;
      if (stream[i] <= 8'd2) begin
        for (int k = 0; k < 4; k++) e.imm = e.imm + (32'(stream[i+2+k]) << (8 * k));
        i = i + 6;
      end else begin
        i = i + 2;
      end
      exp_q.push_back(e);
    end
    exp_consumed = i;
  endfunction

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stream.push_back(v[8*k +: 8]);
  endtask

  task automatic gen_random(input int n_instr, input int bad_pct);
    stream.delete();
    for (int k = 0; k < n_instr; k++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(99);
      if (r < bad_pct) begin
        op = ($urandom_range(1) == 1) ? 8'h00 : 8'($urandom_range(5, 255));
        stream.push_back(op);
        for (int b = 0; b < 5; b++) stream.push_back(8'($urandom));
      end else begin
        op = 8'($urandom_range(1, 4));
        stream.push_back(op);
        if (r < 2 * bad_pct) stream.push_back(8'($urandom_range(8, 255)));
        else                 stream.push_back(8'($urandom_range(0, 7)));
        if (op <= 8'd2) for (int b = 0; b < 4; b++) stream.push_back(8'($urandom));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; iss_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rst_iss_valid"}, 32'(iss_valid), 32'd0);
    check({tag, "_rst_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_rst_iss_op"},    32'(iss_op),    32'd0);
    check({tag, "_rst_iss_reg"},   32'(iss_reg),   32'd0);
    check({tag, "_rst_iss_imm"},   iss_imm,        32'd0);
    check({tag, "_rst_pc"},        32'(pc),        32'd0);
    check({tag, "_rst_err"},       32'(err),       32'd0);
    check({tag, "_rst_err_pc"},    32'(err_pc),    32'd0);
    rst = 1'b0;
  endtask

  // Offer the stream byte-by-byte without waiting on in_ready; only used where the decoder must accept.
  task automatic feed_raw();
    for (int k = 0; k < stream.size(); k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = stream[k]; iss_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input string tag, input int valid_pct, input int ready_pct, input int stall);
    int idx, cyc, err_cyc, budget, stall_left;
    bit done;
    exp_t e;
    parse();
    idx = 0; cyc = 0; err_cyc = 0; done = 1'b0; stall_left = stall;
    budget = 20 * stream.size() + 100;
    while (!done) begin
      @(negedge clk);
      if (iss_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_issue"}, 32'(iss_valid), 32'd0);
        end else begin
          e = exp_q[0];
          check({tag, "_op"},  32'(iss_op),  32'(e.op));
          check({tag, "_reg"}, 32'(iss_reg), 32'(e.rg));
          check({tag, "_imm"}, iss_imm,      e.imm);
        end
        check({tag, "_in_ready_during_issue"}, 32'(in_ready), 32'd0);
      end
      if (err) begin
        check({tag, "_err_blocks_handshakes"}, 32'({in_ready, iss_valid}), 32'd0);
        err_cyc++;
      end
      if (err_cyc >= 4) begin
        done = 1'b1;
      end else if (idx == stream.size() && !iss_valid && exp_q.size() == 0) begin
        done = 1'b1;
      end else if (cyc > budget) begin
        check({tag, "_cycle_budget"}, 32'(cyc), 32'(budget));
        done = 1'b1;
      end
      if (!done) begin
        in_valid = (idx < stream.size()) && ($urandom_range(99) < valid_pct);
        in_data  = in_valid ? stream[idx] : 8'($urandom);
        if (iss_valid && stall_left > 0) begin
          iss_ready = 1'b0;
          stall_left--;
        end else begin
          iss_ready = ($urandom_range(99) < ready_pct);
        end
        if (in_valid && in_ready) idx++;
        if (iss_valid && iss_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        cyc++;
      end
    end
    in_valid = 1'b0; iss_ready = 1'b0;
    check({tag, "_pc"},           32'(pc),           32'(16'(exp_consumed)));
    check({tag, "_err"},          32'(err),          32'(exp_err));
    check({tag, "_err_pc"},       32'(err_pc),       32'(exp_err_pc));
    check({tag, "_bytes_taken"},  32'(idx),          32'(exp_consumed));
    check({tag, "_issues_left"},  32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset("init");

    stream.delete(); push_bytes(64'h0102_7856_3412, 6);
    run_stream("movi", 100, 100, 0);

    do_reset("r1");
    stream.delete(); push_bytes(64'h0207_0000_C03F_0407, 8);
    run_stream("movf_popf", 100, 100, 0);

    do_reset("r2");
    stream.delete(); push_bytes(64'h0300, 2);
    run_stream("backpressure", 100, 100, 5);

    do_reset("r3");
    stream.delete(); push_bytes(64'h0301_0302_0901_02, 7);
    run_stream("bad_opcode", 100, 100, 0);
    do_reset("after_err");
    stream.delete(); push_bytes(64'h0105_DDCC_BBAA, 6);
    run_stream("resume", 100, 100, 0);

    do_reset("r4");
    stream.delete(); push_bytes(64'h0108_1122_3344, 6);
    run_stream("bad_reg", 100, 100, 0);

    do_reset("r5");
    stream.delete(); push_bytes(64'h0103_AABB_CC, 5);
    feed_raw();
    check("mid_imm_no_issue", 32'(iss_valid), 32'd0);
    check("mid_imm_pc",       32'(pc),        32'd5);
    do_reset("mid_imm");
    stream.delete(); push_bytes(64'h0301, 2);
    run_stream("popi_after_rst", 100, 100, 0);

    do_reset("r6");
    stream.delete(); push_bytes(64'h0402, 2);
    feed_raw();
    check("mid_issue_valid", 32'(iss_valid), 32'd1);
    do_reset("mid_issue");

    for (int t = 0; t < 12; t++) begin
      do_reset($sformatf("rand%0d", t));
      gen_random(20, 4);
      run_stream($sformatf("rand%0d", t), 70, 60, 0);
    end

    do_reset("wrap");
    stream.delete();
    for (int k = 0; k < 10922; k++) begin
      stream.push_back(8'h01);
      stream.push_back(8'($urandom_range(0, 7)));
      for (int b = 0; b < 4; b++) stream.push_back(8'($urandom));
    end
    for (int k = 0; k < 3; k++) push_bytes(64'h0306, 2);
    run_stream("pc_wrap", 100, 100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
